// File: rtl/lcd_cmd_scheduler.sv
// Command scheduler for the 4-bit LCD engine: power-up wait, fixed init sequence,
// then round-robin host/refresh arbitration into a FIFO popped by the engine.
module lcd_cmd_scheduler #(
  parameter int DEPTH          = 8,
  parameter int POWERUP_CYCLES = 750000,
  parameter int LVL_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_valid,
  input  logic [9:0]       host_word,
  output logic             host_ready,
  input  logic             refresh_valid,
  input  logic [9:0]       refresh_word,
  output logic             refresh_ready,
  output logic [9:0]       cmd_word,
  output logic             cmd_valid,
  input  logic             cmd_req,
  output logic             init_done,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int DATA_W = 10;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [2:0]       INIT_LAST = 3'd5;
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

  localparam logic [1:0] PWR_WAIT  = 2'd0;
  localparam logic [1:0] INIT_LOAD = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;

  // HD44780 4-bit init: wake x2, 4-bit/2-line, entry mode, display on, clear.
  function automatic logic [DATA_W-1:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    init_word = 10'h033;
      3'd1:    init_word = 10'h032;
      3'd2:    init_word = 10'h028;
      3'd3:    init_word = 10'h006;
      3'd4:    init_word = 10'h00C;
      3'd5:    init_word = 10'h001;
      default: init_word = 10'h000;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              rr_q, rr_d;
  logic              init_done_q, init_done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run, full, empty;
  logic              host_gnt, ref_gnt, host_acc, ref_acc;
  logic              init_push, push, pop;
  logic [DATA_W-1:0] push_word;

  always_comb begin
    run   = (state_q == RUN);
    full  = (level_q == LVL_FULL);
    empty = (level_q == '0);
    // rr_q == 0 favours host when both request
    host_gnt = run && host_valid && (!refresh_valid || !rr_q);
    ref_gnt  = run && refresh_valid && (!host_valid || rr_q);
    host_ready    = host_gnt && !full;
    refresh_ready = ref_gnt && !full;
    host_acc  = host_ready;
    ref_acc   = refresh_ready;
    init_push = (state_q == INIT_LOAD) && !full;
    push      = init_push || host_acc || ref_acc;
    pop       = cmd_req && !empty;
    push_word = init_push ? init_word(idx_q) : (host_acc ? host_word : refresh_word);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = INIT_LOAD;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      INIT_LOAD: begin
        if (init_push) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == INIT_LAST) state_d = RUN;
        end
      end
      RUN: begin
        if (host_acc)     rr_d = 1'b1;
        else if (ref_acc) rr_d = 1'b0;
      end
      default: state_d = PWR_WAIT;
    endcase
    init_done_d = init_done_q || (state_d == RUN);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rr_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rr_q        <= rr_d;
      init_done_q <= init_done_d;
    end
  end

  // FIFO storage holds data only; occupancy is governed by the pointers above
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= push_word;
  end

  assign cmd_valid  = !empty;
  assign cmd_word   = empty ? '0 : mem_q[rd_ptr_q];
  assign init_done  = init_done_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Bench for lcd_cmd_scheduler: scenario tasks plus random traffic, all checked
// cycle-by-cycle against a queue-based model of the scheduler.
module tb_lcd_cmd_scheduler;

  localparam int DEPTH = 8;
  localparam int PWR   = 20;
  localparam int LVL_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             host_valid = 1'b0;
  logic [9:0]       host_word = '0;
  logic             host_ready;
  logic             refresh_valid = 1'b0;
  logic [9:0]       refresh_word = '0;
  logic             refresh_ready;
  logic [9:0]       cmd_word;
  logic             cmd_valid;
  logic             cmd_req = 1'b0;
  logic             init_done;
  logic [LVL_W-1:0] fifo_level;

  lcd_cmd_scheduler #(.DEPTH(DEPTH), .POWERUP_CYCLES(PWR), .LVL_W(LVL_W)) dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_word(host_word), .host_ready(host_ready),
    .refresh_valid(refresh_valid), .refresh_word(refresh_word), .refresh_ready(refresh_ready),
    .cmd_word(cmd_word), .cmd_valid(cmd_valid), .cmd_req(cmd_req),
    .init_done(init_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Reference model: phase 0 = power-up wait, 1 = init load, 2 = run
  int         m_phase = 0;
  int         m_cnt   = 0;
  int         m_idx   = 0;
  int         m_rr    = 0;
  int         h_acc   = 0;
  int         r_acc   = 0;
  logic [9:0] m_q[$];
  logic [9:0] init_rom [6] = '{10'h033, 10'h032, 10'h028, 10'h006, 10'h00C, 10'h001};

  logic [17:0] obs;
  assign obs = {init_done, host_ready, refresh_ready, cmd_valid, cmd_word, fifo_level};

  function automatic logic [17:0] exp_vec();
    int sz = m_q.size();
    logic run = (m_phase == 2);
    logic hg  = run && (sz < DEPTH) && host_valid && (!refresh_valid || m_rr == 0);
    logic rg  = run && (sz < DEPTH) && refresh_valid && (!host_valid || m_rr == 1);
    logic [9:0] head = (sz != 0) ? m_q[0] : 10'h000;
    return {run, hg, rg, sz != 0, head, LVL_W'(sz)};
  endfunction

  task automatic model_update();
    int  sz = m_q.size();
    logic full = (sz >= DEPTH);
    logic hg = (m_phase == 2) && !full && host_valid && (!refresh_valid || m_rr == 0);
    logic rg = (m_phase == 2) && !full && refresh_valid && (!host_valid || m_rr == 1);
    if (reset) begin
      m_phase = 0; m_cnt = 0; m_idx = 0; m_rr = 0;
      m_q.delete();
    end else begin
      if (cmd_req && sz > 0) void'(m_q.pop_front());
      case (m_phase)
        0: if (m_cnt == PWR - 1) begin m_phase = 1; m_idx = 0; end else m_cnt++;
        1: if (!full) begin
             m_q.push_back(init_rom[m_idx]);
             m_idx++;
             if (m_idx == 6) m_phase = 2;
           end
        default: if (hg) begin
                   m_q.push_back(host_word); m_rr = 1; h_acc++;
                 end else if (rg) begin
                   m_q.push_back(refresh_word); m_rr = 0; r_acc++;
                 end
      endcase
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); model_update(); @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_powerup_init();
    reset = 1'b0;
    for (int i = 0; i < PWR + 8; i++) begin
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++;
        $display("FAIL powerup_init cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      advance();
    end
    #1;
    n_checks++;
    if (fifo_level !== 4'd6 || cmd_word !== 10'h033 || init_done !== 1'b1) begin
      n_fails++;
      $display("FAIL init_result level=%0d word=%h init_done=%b exp level=6 word=033 init_done=1",
               fifo_level, cmd_word, init_done);
    end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 3; j++) begin
        cmd_req = (j == 0);
        #1;
        n_checks++;
        if (obs !== exp_vec()) begin
          n_fails++;
          $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
        end
        advance();
      end
    end
    cmd_req = 1'b0;
    #1;
    n_checks++;
    if (fifo_level !== 4'd0 || cmd_valid !== 1'b0 || cmd_word !== 10'h000) begin
      n_fails++;
      $display("FAIL drain_empty level=%0d valid=%b word=%h exp 0/0/000", fifo_level, cmd_valid, cmd_word);
    end
  endtask

  task automatic test_fill();
    host_valid = 1'b1; refresh_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      host_word    = 10'h200 + 10'(h_acc);
      refresh_word = 10'h100 + 10'(r_acc);
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++;
        $display("FAIL fill cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      advance();
    end
    #1;
    n_checks++;
    if (fifo_level !== 4'd8 || host_ready !== 1'b0 || refresh_ready !== 1'b0 || cmd_word !== 10'h200) begin
      n_fails++;
      $display("FAIL fill_full level=%0d hr=%b rr=%b head=%h exp 8/0/0/200",
               fifo_level, host_ready, refresh_ready, cmd_word);
    end
    host_valid = 1'b0; refresh_valid = 1'b0;
  endtask

  task automatic test_full_pop();
    host_valid = 1'b1; host_word = 10'h200 + 10'(h_acc); cmd_req = 1'b1;
    #1;
    n_checks++;
    if (host_ready !== 1'b0 || obs !== exp_vec()) begin
      n_fails++;
      $display("FAIL full_pop_same got=%h exp=%h (host_ready must be 0)", obs, exp_vec());
    end
    advance();
    cmd_req = 1'b0; host_word = 10'h200 + 10'(h_acc);
    #1;
    n_checks++;
    if (host_ready !== 1'b1 || fifo_level !== 4'd7 || obs !== exp_vec()) begin
      n_fails++;
      $display("FAIL full_pop_next hr=%b level=%0d exp hr=1 level=7", host_ready, fifo_level);
    end
    advance();
    host_valid = 1'b0;
    #1;
    n_checks++;
    if (fifo_level !== 4'd8 || obs !== exp_vec()) begin
      n_fails++;
      $display("FAIL full_refill level=%0d exp 8", fifo_level);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10 && m_q.size() > 3; i++) begin
      cmd_req = 1'b1;
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++;
        $display("FAIL b2b_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      advance();
    end
    for (int i = 0; i < 20; i++) begin
      host_valid = 1'b1; cmd_req = 1'b1;
      host_word = 10'h200 + 10'(h_acc);
      #1;
      n_checks++;
      if (obs !== exp_vec() || fifo_level !== 4'd3) begin
        n_fails++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h level=%0d exp 3", cyc, obs, exp_vec(), fifo_level);
      end
      advance();
    end
    host_valid = 1'b0; cmd_req = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      host_valid    = ($urandom_range(0, 1) == 1);
      refresh_valid = ($urandom_range(0, 1) == 1);
      host_word     = 10'($urandom);
      refresh_word  = 10'($urandom);
      cmd_req       = ($urandom_range(0, 2) == 0) || (i >= 200 && $urandom_range(0, 1) == 1);
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      advance();
    end
    host_valid = 1'b0; refresh_valid = 1'b0; cmd_req = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 40 && m_q.size() != 5; i++) begin
      cmd_req    = (m_q.size() > 5);
      host_valid = (m_q.size() < 5);
      host_word  = 10'h200 + 10'(h_acc);
      advance();
    end
    cmd_req = 1'b0; host_valid = 1'b0;
    #1;
    n_checks++;
    if (fifo_level !== 4'd5) begin
      n_fails++;
      $display("FAIL mid_reset_setup level=%0d exp 5", fifo_level);
    end
    reset = 1'b1;
    advance();
    reset = 1'b0; host_valid = 1'b1; refresh_valid = 1'b1;
    #1;
    n_checks++;
    if (fifo_level !== 4'd0 || cmd_valid !== 1'b0 || init_done !== 1'b0 ||
        host_ready !== 1'b0 || refresh_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL mid_reset level=%0d valid=%b init=%b hr=%b rr=%b exp all 0",
               fifo_level, cmd_valid, init_done, host_ready, refresh_ready);
    end
    for (int i = 0; i < PWR + 6; i++) begin
      if (i == 2) begin host_valid = 1'b0; refresh_valid = 1'b0; end
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++;
        $display("FAIL reinit cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      advance();
    end
    #1;
    n_checks++;
    if (fifo_level !== 4'd6 || cmd_word !== 10'h033 || init_done !== 1'b1) begin
      n_fails++;
      $display("FAIL reinit_result level=%0d word=%h init=%b exp 6/033/1", fifo_level, cmd_word, init_done);
    end
  endtask

  initial begin
    test_reset();
    test_powerup_init();
    test_drain();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_scheduler.md
Name: lcd_cmd_scheduler

Overview:
Feeds the 4-bit LCD command engine with 10-bit command words {lcd_rw, lcd_rs, data[7:0]}. After reset it waits for the LCD power-up time and then queues a fixed initialisation sequence. Once initialisation is done, it arbitrates round-robin between two requesters, host and refresh, into an internal FIFO. The FIFO head is presented to the command engine, which pops it with a one-cycle request pulse.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 4.
POWERUP_CYCLES, 750000, clk cycles to wait before the init sequence (15 ms @ 50 MHz).
LVL_W, 4, width of fifo_level; must equal log2(DEPTH)+1.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
host_valid  in  1  host has a word on host_word
host_word  in  10  {rw, rs, data[7:0]} from host
host_ready  out  1  host word accepted this cycle when host_valid && host_ready
refresh_valid  in  1  refresh source has a word
refresh_word  in  10  refresh word, same format
refresh_ready  out  1  refresh word accepted this cycle when refresh_valid && refresh_ready
cmd_word  out  10  FIFO head to command engine (its buffer input)
cmd_valid  out  1  FIFO non-empty (command engine's next_command input)
cmd_req  in  1  one-cycle pulse from command engine: head consumed, pop
init_done  out  1  high once the init sequence is queued; stays high until reset
fifo_level  out  LVL_W  current occupancy, 0..DEPTH

Behaviour:
- Reset values: FSM = PWR_WAIT, wait counter 0, read and write pointers 0, fifo_level 0, cmd_valid 0, cmd_word 10'h000, host_ready 0, refresh_ready 0, init_done 0, round-robin pointer favours host.
- Reset asserted mid-operation discards all FIFO contents and restarts from PWR_WAIT, including the full power-up wait.
- FSM states:
  - PWR_WAIT: counter increments each cycle. When counter == POWERUP_CYCLES-1, go to INIT_LOAD with index 0.
  - INIT_LOAD: pushes one ROM word per cycle, in order: 10'h033, 10'h032, 10'h028, 10'h006, 10'h00C, 10'h001. After the 6th push go to RUN. DEPTH >= 4 and the FIFO is empty on entry; if the FIFO is full in a given cycle, the push stalls that cycle.
  - RUN: arbitration enabled; init_done = 1 (registered, asserted in the cycle RUN is entered).
- Ready signals (combinational from registered state):
  - host_ready and refresh_ready = 0 outside RUN.
  - In RUN, a requester's ready = (FIFO not full) && (that requester is granted).
- Grant in RUN:
  - Only one valid requester: it is granted.
  - Both valid: the round-robin pointer decides. After each accepted push, the pointer moves to the other requester.
  - Neither valid: no grant, pointer unchanged.
  - At most one push per cycle.
- Full FIFO: both ready signals are 0, even if cmd_req pops the same cycle (no pass-through). Ready rises the cycle after the pop.
- Pop: on cmd_req && cmd_valid, rd_ptr advances.
  - cmd_req while empty is ignored; no pointer change, no error.
- Simultaneous push and pop: both happen, fifo_level unchanged.
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- fifo_level = writes minus reads; never exceeds DEPTH, never underflows.
- cmd_word = mem[rd_ptr] when non-empty, 10'h000 when empty. It stays stable until a pop, because the command engine samples it across multiple cycles.
- cmd_valid = (fifo_level != 0). New data is visible the cycle after the push (registered write, no bypass).
- Words are stored unmodified; no decoding of the clear (10'h001) command here, since the long wait is the command engine's job.

Test Plan:
1. POWERUP_CYCLES=20, no cmd_req. Expect:
   - cmd_valid stays 0 through cycle 20.
   - The 6 init words are pushed on consecutive cycles, after which fifo_level=6, init_done=1, and host_ready and refresh_ready are 0 throughout.
   - cmd_word=10'h033.
2. After init, pulse cmd_req 6 times spaced 3 cycles apart → cmd_word steps 033, 032, 028, 006, 00C, 001, then cmd_valid=0 and cmd_word=000. One extra cmd_req while empty → level stays 0.
3. In RUN with an empty FIFO, hold host_valid and refresh_valid high continuously (host words 0x200+n, refresh words 0x100+n), no pops → words accepted in order host, refresh, host, …, one per cycle. With DEPTH=8, the FIFO fills in 8 cycles, then both ready signals are 0 and fifo_level=8.
4. FIFO full, cmd_req asserted together with host_valid → in that cycle host_ready=0 and level drops to 7. The next cycle host_ready=1 and the push brings level back to 8.
5. Steady state with level=3: push and pop in the same cycle → level stays 3. Run 20 pushes/pops total to exercise pointer wrap; the output order matches input order with no loss or duplication.
6. Assert reset for 1 cycle with level=5 in RUN → next cycle fifo_level=0, cmd_valid=0, init_done=0, both ready signals 0. The full init sequence then repeats after POWERUP_CYCLES.
